// File: rtl/a2s_controller.sv
// AXI-read-to-stream controller: fetches 16-beat bursts from an OCM ring into a
// ping-pong buffer and streams them out. Optional A2S_RESP_CHECK_EN adds response checking.
//
// state | meaning
// IDLE  | waiting for en and a free write half
// ADDR  | read address presented, waiting for arready
// DATA  | accepting 16 beats into the write half
module a2s_controller #(
  parameter logic [31:0] ocm_haddr = 32'hfffc0000,
  parameter int          ocm_width = 16
) (
  input  logic        AXI_clk,
  input  logic        rst,
  input  logic        sync,
  input  logic        en,
  output logic [31:0] AXI_raddr,
  output logic        AXI_arvalid,
  input  logic        AXI_arready,
  input  logic [31:0] AXI_rdata,
  input  logic        AXI_rvalid,
  input  logic        AXI_rlast,
  output logic        AXI_rready,
  input  logic [1:0]  AXI_rresp,
  output logic [31:0] Odata,
  output logic        Ovalid,
  input  logic        Oready,
  output logic [31:0] a2s_cnt,
  output logic        a2s_err
);

  localparam int BW = ocm_width - 6;

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA} state_t;

  state_t        state, state_nx;
  logic [BW-1:0] bidx;
  logic [1:0]    full, full_nx;
  logic          wh, rh;
  logic [3:0]    rptr, beat;
  logic          pending;
  logic [31:0]   mem [0:31];
  logic [31:0]   boff;
  logic          start, beat_acc, last_beat, clear, fill_done, drain, drain_last;

  always_ff @(posedge AXI_clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx    = state;
    AXI_arvalid = 1'b0;
    AXI_rready  = 1'b0;
    start       = 1'b0;
    case (state)
      S_IDLE: begin
        if (en && !full[wh] && !pending && !sync) begin
          state_nx = S_ADDR;
          start    = 1'b1;
        end
      end
      S_ADDR: begin
        AXI_arvalid = 1'b1;
        if (AXI_arready) state_nx = S_DATA;
      end
      S_DATA: begin
        AXI_rready = 1'b1;
        if (AXI_rvalid && beat == 4'd15) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  assign beat_acc   = AXI_rready && AXI_rvalid;
  assign last_beat  = beat_acc && (beat == 4'd15);
  // a sync raised during a burst is deferred until its last beat is taken
  assign clear      = ((state == S_IDLE) && sync) || (last_beat && (pending || sync));
  assign fill_done  = last_beat && !pending && !sync;
  assign Ovalid     = full[rh] && !pending;
  assign Odata      = mem[{rh, rptr}];
  assign drain      = Ovalid && Oready;
  assign drain_last = drain && (rptr == 4'd15);

  always_comb begin
    boff = '0;
    boff[ocm_width-1:6] = bidx;
  end

  always_comb begin
    full_nx = full;
    if (fill_done)  full_nx[wh] = 1'b1;
    if (drain_last) full_nx[rh] = 1'b0;
  end

  always_ff @(posedge AXI_clk or negedge rst) begin
    if (!rst) begin
      AXI_raddr <= ocm_haddr;
      beat      <= '0;
      bidx      <= '0;
      full      <= '0;
      wh        <= 1'b0;
      rh        <= 1'b0;
      rptr      <= '0;
      pending   <= 1'b0;
      a2s_cnt   <= '0;
    end else begin
      if (start)    AXI_raddr <= ocm_haddr + boff;
      if (beat_acc) beat <= beat + 4'd1;
      if (clear) begin
        bidx    <= '0;
        full    <= '0;
        wh      <= 1'b0;
        rh      <= 1'b0;
        rptr    <= '0;
        pending <= 1'b0;
        a2s_cnt <= '0;
      end else begin
        if ((state != S_IDLE) && sync) pending <= 1'b1;
        full <= full_nx;
        if (fill_done) begin
          wh      <= ~wh;
          bidx    <= bidx + 1'b1;
          a2s_cnt <= a2s_cnt + 32'd1;
        end
        if (drain) begin
          rptr <= rptr + 4'd1;
          if (rptr == 4'd15) rh <= ~rh;
        end
      end
    end
  end

  always_ff @(posedge AXI_clk) begin
    if (beat_acc && !pending) mem[{wh, beat}] <= AXI_rdata;
  end

`ifdef A2S_RESP_CHECK_EN
  logic err_beat;
  assign err_beat = beat_acc && ((AXI_rresp != 2'b00) || (AXI_rlast != (beat == 4'd15)));

  always_ff @(posedge AXI_clk or negedge rst) begin
    if (!rst)          a2s_err <= 1'b0;
    else if (clear)    a2s_err <= 1'b0;
    else if (err_beat) a2s_err <= 1'b1;
  end
`else
  logic unused_resp;
  assign unused_resp = ^{AXI_rresp, AXI_rlast};
  assign a2s_err     = 1'b0;
`endif

endmodule

// File: tb/tb_a2s_controller.sv
// Directed bench for a2s_controller; a second instance with a 256-byte ring
// shares the stimulus to exercise ring wrap.
module tb_a2s_controller;

  logic        AXI_clk, rst, sync, en;
  logic        AXI_arready, AXI_rvalid, Oready;
  logic [31:0] AXI_rdata;
  logic        AXI_rlast;
  logic [1:0]  AXI_rresp;
  logic [31:0] AXI_raddr, Odata, a2s_cnt;
  logic        AXI_arvalid, AXI_rready, Ovalid, a2s_err;
  logic [31:0] raddr8, odata8, cnt8;
  logic        arvalid8, rready8, ovalid8, err8;

  logic [31:0] word_ctr;
  logic [3:0]  beat_ctr;
  logic        disc, rnd, err_inject;
  logic [31:0] raddr_q[$], raddr8_q[$], in_q[$], out_q[$], out8_q[$];
  int          total, bad;

`ifdef A2S_RESP_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  a2s_controller u_dut (
    .AXI_clk(AXI_clk), .rst(rst), .sync(sync), .en(en),
    .AXI_raddr(AXI_raddr), .AXI_arvalid(AXI_arvalid), .AXI_arready(AXI_arready),
    .AXI_rdata(AXI_rdata), .AXI_rvalid(AXI_rvalid), .AXI_rlast(AXI_rlast),
    .AXI_rready(AXI_rready), .AXI_rresp(AXI_rresp),
    .Odata(Odata), .Ovalid(Ovalid), .Oready(Oready),
    .a2s_cnt(a2s_cnt), .a2s_err(a2s_err)
  );

  a2s_controller #(.ocm_width(8)) u_dut8 (
    .AXI_clk(AXI_clk), .rst(rst), .sync(sync), .en(en),
    .AXI_raddr(raddr8), .AXI_arvalid(arvalid8), .AXI_arready(AXI_arready),
    .AXI_rdata(AXI_rdata), .AXI_rvalid(AXI_rvalid), .AXI_rlast(AXI_rlast),
    .AXI_rready(rready8), .AXI_rresp(AXI_rresp),
    .Odata(odata8), .Ovalid(ovalid8), .Oready(Oready),
    .a2s_cnt(cnt8), .a2s_err(err8)
  );

  initial AXI_clk = 1'b0;
  always #5 AXI_clk = ~AXI_clk;

  assign AXI_rdata = word_ctr;
  assign AXI_rlast = (beat_ctr == 4'd15);
  assign AXI_rresp = (err_inject && beat_ctr == 4'd3) ? 2'b10 : 2'b00;

  // slave data source and stream monitors
  always @(posedge AXI_clk) begin
    if (!rst) begin
      word_ctr <= '0;
      beat_ctr <= '0;
    end else begin
      if (AXI_arvalid && AXI_arready) raddr_q.push_back(AXI_raddr);
      if (arvalid8 && AXI_arready)    raddr8_q.push_back(raddr8);
      if (AXI_rvalid && AXI_rready) begin
        if (!disc) in_q.push_back(AXI_rdata);
        word_ctr <= word_ctr + 32'd1;
        beat_ctr <= beat_ctr + 4'd1;
      end
      if (Ovalid && Oready)  out_q.push_back(Odata);
      if (ovalid8 && Oready) out8_q.push_back(odata8);
    end
  end

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge AXI_clk);
      if (rnd) begin
        AXI_rvalid = 1'($urandom_range(0, 1));
        Oready     = 1'($urandom_range(0, 1));
      end
    end
  endtask

  initial begin
    total = 0; bad = 0;
    rst = 1'b0; sync = 1'b0; en = 1'b0;
    AXI_arready = 1'b1; AXI_rvalid = 1'b1; Oready = 1'b0;
    disc = 1'b0; rnd = 1'b0; err_inject = 1'b0;

    // reset state
    cyc(3);
    chk32("rst_raddr", AXI_raddr, 32'hfffc0000);
    chk1("rst_arvalid", AXI_arvalid, 1'b0);
    chk1("rst_rready", AXI_rready, 1'b0);
    chk1("rst_ovalid", Ovalid, 1'b0);
    chk32("rst_cnt", a2s_cnt, 32'd0);
    chk1("rst_err", a2s_err, 1'b0);
    rst = 1'b1;
    cyc(1);

    // first burst, Oready held low to fill both halves
    en = 1'b1;
    cyc(1);
    chk1("a_arvalid", AXI_arvalid, 1'b1);
    chk32("a_raddr0", AXI_raddr, 32'hfffc0000);
    chk32("a_raddr8_0", raddr8, 32'hfffc0000);
    cyc(1);
    chk1("a_arvalid_drop", AXI_arvalid, 1'b0);
    chk1("a_rready", AXI_rready, 1'b1);
    chk1("a_rready8", rready8, 1'b1);
    cyc(15);
    chk1("a_ovalid_early", Ovalid, 1'b0);
    chk32("a_cnt_early", a2s_cnt, 32'd0);
    cyc(1);
    chk1("a_ovalid_first", Ovalid, 1'b1);
    chk32("a_odata_first", Odata, 32'd0);
    chk32("a_cnt1", a2s_cnt, 32'd1);
    cyc(30);
    chk32("a_bursts_stalled", 32'(raddr_q.size()), 32'd2);
    chk32("a_raddr1", raddr_q[1], 32'hfffc0040);
    chk1("a_idle_arvalid", AXI_arvalid, 1'b0);
    chk1("a_idle_rready", AXI_rready, 1'b0);
    chk1("a_hold_ovalid", Ovalid, 1'b1);
    chk32("a_hold_odata", Odata, 32'd0);
    chk32("a_cnt2", a2s_cnt, 32'd2);

    // back-to-back drain, en dropped mid third burst
    Oready = 1'b1;
    cyc(32);
    chk32("a_nogap_len", 32'(out_q.size()), 32'd32);
    chk32("a_word15", out_q[15], 32'd15);
    chk32("a_word31", out_q[31], 32'd31);
    en = 1'b0;
    cyc(40);
    chk32("a_cnt3", a2s_cnt, 32'd3);
    chk32("a_bursts3", 32'(raddr_q.size()), 32'd3);
    chk32("a_raddr2", raddr_q[2], 32'hfffc0080);
    chk32("a_len48", 32'(out_q.size()), 32'd48);

    // ring wrap on the 256-byte instance
    en = 1'b1;
    cyc(45);
    en = 1'b0;
    cyc(40);
    chk32("b_raddr3", raddr_q[3], 32'hfffc00c0);
    chk32("b_raddr4", raddr_q[4], 32'hfffc0100);
    chk32("b_raddr8_3", raddr8_q[3], 32'hfffc00c0);
    chk32("b_raddr8_4_wrap", raddr8_q[4], 32'hfffc0000);
    chk32("b_raddr8_5", raddr8_q[5], 32'hfffc0040);
    chk32("b_cnt6", a2s_cnt, 32'd6);
    chk32("b_cnt8_6", cnt8, 32'd6);
    chk32("b_len96", 32'(out_q.size()), 32'd96);

    // sync on the 5th beat of a burst
    disc = 1'b1;
    en = 1'b1;
    cyc(1);
    chk32("s_raddr", AXI_raddr, 32'hfffc0180);
    chk32("s_raddr8", raddr8, 32'hfffc0080);
    cyc(5);
    sync = 1'b1;
    cyc(1);
    sync = 1'b0;
    chk1("s_pending_ovalid", Ovalid, 1'b0);
    chk1("s_pending_rready", AXI_rready, 1'b1);
    cyc(11);
    chk32("s_cnt_cleared", a2s_cnt, 32'd0);
    chk32("s_cnt8_cleared", cnt8, 32'd0);
    chk1("s_ovalid_none", Ovalid, 1'b0);
    chk1("s_idle_rready", AXI_rready, 1'b0);
    disc = 1'b0;
    cyc(1);
    chk1("s_restart_arvalid", AXI_arvalid, 1'b1);
    chk32("s_restart_raddr", AXI_raddr, 32'hfffc0000);
    chk32("s_restart_raddr8", raddr8, 32'hfffc0000);
    en = 1'b0;
    cyc(40);
    chk32("s_cnt1", a2s_cnt, 32'd1);
    chk32("s_len112", 32'(out_q.size()), 32'd112);

    // random rvalid / Oready
    rnd = 1'b1;
    en = 1'b1;
    cyc(400);
    rnd = 1'b0;
    en = 1'b0;
    AXI_rvalid = 1'b1;
    Oready = 1'b1;
    cyc(80);
    chk1("r_idle_ovalid", Ovalid, 1'b0);

    // bad response on beat 3
    err_inject = 1'b1;
    en = 1'b1;
    cyc(5);
    chk1("e_err_before", a2s_err, 1'b0);
    cyc(1);
    chk1("e_err_set", a2s_err, EXP_ERR);
    err_inject = 1'b0;
    en = 1'b0;
    cyc(40);
    chk1("e_err_held", a2s_err, EXP_ERR);
    chk1("e_err8_held", err8, EXP_ERR);
    sync = 1'b1;
    cyc(1);
    sync = 1'b0;
    chk1("e_err_cleared", a2s_err, 1'b0);
    chk32("e_cnt_cleared", a2s_cnt, 32'd0);
    chk32("e_cnt8_cleared", cnt8, 32'd0);

    // stream scoreboard: every accepted, non-discarded beat exactly once in order
    chk32("sb_len", 32'(out_q.size()), 32'(in_q.size()));
    chk32("sb8_len", 32'(out8_q.size()), 32'(in_q.size()));
    for (int i = 0; i < out_q.size() && i < in_q.size(); i++)
      chk32($sformatf("sb_word%0d", i), out_q[i], in_q[i]);
    for (int i = 0; i < out8_q.size() && i < in_q.size(); i++)
      chk32($sformatf("sb8_word%0d", i), out8_q[i], in_q[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
